// File: rtl/ball_motion_engine_if.sv
// Ball hand-over bundle between two engines: rx carries an arriving ball, tx a departing one.
// master = engine side (accepts rx, offers tx); slave = the peer feeding/draining it.
interface ball_motion_engine_if;
    logic              rx_valid;
    logic              rx_ready;
    logic [9:0]        rx_y;
    logic signed [7:0] rx_vy;
    logic [1:0]        rx_grav;
    logic [7:0]        rx_speed;
    logic              tx_valid;
    logic              tx_ready;
    logic [9:0]        tx_y;
    logic signed [7:0] tx_vy;
    logic [1:0]        tx_grav;
    logic [7:0]        tx_speed;

    modport master (
        input  rx_valid, rx_y, rx_vy, rx_grav, rx_speed, tx_ready,
        output rx_ready, tx_valid, tx_y, tx_vy, tx_grav, tx_speed
    );

    modport slave (
        output rx_valid, rx_y, rx_vy, rx_grav, rx_speed, tx_ready,
        input  rx_ready, tx_valid, tx_y, tx_vy, tx_grav, tx_speed
    );
endinterface

// File: rtl/ball_motion_engine.sv
// Ball flight engine: accepts a ball, moves it with gravity/bounces, returns it or ends the game.
// Latency: CW clocks of serial divide per speed change, then one step every period+1 clocks.
// Backpressure: rx accepted only in IDLE; tx ball held stable in HANDOFF until tx_ready.
module ball_motion_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int STEP_X      = 10,
    parameter int GRAV_PERIOD = 4,
    parameter int BASE_TICKS  = 270000,
    parameter int CW          = 20,
    parameter int MAX_SCORE   = 15
) (
    input  logic                 clk_25MHZ,
    input  logic                 reset,
    input  logic                 upscale,
    input  logic                 restart,
    input  logic                 collision_detected,
    input  logic [9:0]           estimated_speed,
    ball_motion_engine_if.master bus,
    output logic [9:0]           ball_x,
    output logic [9:0]           ball_y,
    output logic                 moving_left,
    output logic [7:0]           score,
    output logic                 game_over,
    output logic                 win,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, DIV, RUN_LEFT, RUN_RIGHT, HANDOFF, OVER} state_t;

    localparam int              DW        = $clog2(CW);
    localparam logic [CW-1:0]   DIVIDEND  = CW'(BASE_TICKS);
    localparam logic [DW-1:0]   DCNT_LAST = DW'(CW - 1);
    localparam logic [9:0]      STEP      = 10'(STEP_X);
    localparam logic [1:0]      GRAV_LAST = 2'(GRAV_PERIOD - 1);
    localparam logic [7:0]      SCORE_WIN = 8'(MAX_SCORE);

    state_t            state, state_n;
    logic              dir_left, dir_left_n;
    logic [9:0]        x_n, y_n;
    logic signed [7:0] vy, vy_n;
    logic [1:0]        phase, phase_n;
    logic [7:0]        speed, speed_n;
    logic [CW-1:0]     period, period_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [CW-1:0]     rem, rem_n;
    logic [CW-1:0]     dvd, dvd_n;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic [7:0]        score_n;
    logic              over_n, win_n;

    logic [9:0]         x_lim, y_max;
    logic               rx_fire, step_due, grav_wrap, q_bit;
    logic [CW:0]        divisor, rem_sh;
    logic [CW-1:0]      quot;
    logic signed [7:0]  vy_adv, vy_step;
    logic [1:0]         phase_adv;
    logic signed [10:0] y_sum;
    logic [9:0]         y_step;
    logic [10:0]        x_right;
    logic [7:0]         est_sat, score_inc;

    assign x_lim = upscale ? 10'(H_RES - 1) : 10'(H_RES / 2 - 1);
    assign y_max = upscale ? 10'(V_RES - 1) : 10'(V_RES / 2 - 1);

    assign bus.rx_ready = (state == IDLE) && !reset;
    assign rx_fire      = bus.rx_valid && bus.rx_ready;
    assign bus.tx_valid = (state == HANDOFF);
    assign bus.tx_y     = ball_y;
    assign bus.tx_vy    = vy;
    assign bus.tx_grav  = phase;
    assign bus.tx_speed = speed;
    assign busy         = (state != IDLE);
    assign moving_left  = (state == RUN_LEFT) || ((state == DIV) && dir_left);

    // Restoring divider: one quotient bit per clock, quotient shifted into period.
    assign divisor = {{(CW-7){1'b0}}, speed};
    assign rem_sh  = {rem, dvd[CW-1]};
    assign q_bit   = (rem_sh >= divisor);
    assign quot    = {period[CW-2:0], q_bit};

    assign step_due  = (cnt >= period);
    assign grav_wrap = (phase == GRAV_LAST);
    assign vy_adv    = grav_wrap ? vy + 8'sd1 : vy;
    assign phase_adv = grav_wrap ? 2'd0 : phase + 2'd1;
    assign y_sum     = $signed({1'b0, ball_y}) + $signed({{3{vy[7]}}, vy});
    assign x_right   = {1'b0, ball_x} + {1'b0, STEP};

    assign est_sat   = (estimated_speed > 10'd255) ? 8'd255 :
                       (estimated_speed < 10'd2)   ? 8'd2   : estimated_speed[7:0];
    assign score_inc = (score == 8'hFF) ? score : score + 8'd1;

    // Bounce uses the gravity-advanced vy, position uses the old one.
    always_comb begin
        y_step  = y_sum[9:0];
        vy_step = vy_adv;
        if (y_sum >= $signed({1'b0, y_max})) begin
            y_step  = y_max;
            vy_step = -vy_adv;
        end else if (y_sum <= 11'sd0) begin
            y_step  = 10'd0;
            vy_step = -vy_adv;
        end
    end

    always_comb begin
        state_n    = state;
        dir_left_n = dir_left;
        x_n        = ball_x;
        y_n        = ball_y;
        vy_n       = vy;
        phase_n    = phase;
        speed_n    = speed;
        period_n   = period;
        cnt_n      = cnt;
        rem_n      = rem;
        dvd_n      = dvd;
        dcnt_n     = dcnt;
        score_n    = score;
        over_n     = game_over;
        win_n      = win;
        case (state)
            IDLE: begin
                if (rx_fire) begin
                    y_n        = bus.rx_y;
                    vy_n       = bus.rx_vy;
                    phase_n    = bus.rx_grav;
                    speed_n    = (bus.rx_speed == 8'd0) ? 8'd1 : bus.rx_speed;
                    x_n        = x_lim;
                    dir_left_n = 1'b1;
                    state_n    = DIV;
                end
            end
            DIV: begin
                rem_n    = q_bit ? CW'(rem_sh - divisor) : rem_sh[CW-1:0];
                dvd_n    = {dvd[CW-2:0], 1'b0};
                period_n = quot;
                dcnt_n   = dcnt + 1'b1;
                if (dcnt == DCNT_LAST) begin
                    period_n = (quot == '0) ? CW'(1) : quot;
                    cnt_n    = '0;
                    state_n  = dir_left ? RUN_LEFT : RUN_RIGHT;
                end
            end
            RUN_LEFT: begin
                cnt_n = cnt + 1'b1;
                if (collision_detected) begin
                    speed_n    = est_sat;
                    dir_left_n = 1'b0;
                    score_n    = score_inc;
                    state_n    = DIV;
                end else if (step_due) begin
                    cnt_n   = '0;
                    y_n     = y_step;
                    vy_n    = vy_step;
                    phase_n = phase_adv;
                    if (ball_x < STEP) begin
                        x_n     = '0;
                        over_n  = 1'b1;
                        win_n   = 1'b0;
                        state_n = OVER;
                    end else begin
                        x_n = ball_x - STEP;
                    end
                end
            end
            RUN_RIGHT: begin
                cnt_n = cnt + 1'b1;
                if (score == SCORE_WIN) begin
                    over_n  = 1'b1;
                    win_n   = 1'b1;
                    state_n = OVER;
                end else if (step_due) begin
                    cnt_n   = '0;
                    y_n     = y_step;
                    vy_n    = vy_step;
                    phase_n = phase_adv;
                    if (x_right > {1'b0, x_lim}) begin
                        x_n     = x_lim;
                        state_n = HANDOFF;
                    end else begin
                        x_n = ball_x + STEP;
                    end
                end
            end
            HANDOFF: begin
                if (bus.tx_ready) state_n = IDLE;
            end
            OVER: begin
                if (restart) begin
                    score_n = '0;
                    over_n  = 1'b0;
                    win_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Divider sits preloaded whenever it is not running.
        if (state != DIV) begin
            rem_n  = '0;
            dvd_n  = DIVIDEND;
            dcnt_n = '0;
        end
    end

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            state     <= IDLE;
            dir_left  <= 1'b0;
            ball_x    <= '0;
            ball_y    <= '0;
            vy        <= '0;
            phase     <= '0;
            speed     <= 8'd1;
            period    <= CW'(1);
            cnt       <= '0;
            rem       <= '0;
            dvd       <= DIVIDEND;
            dcnt      <= '0;
            score     <= '0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            state     <= state_n;
            dir_left  <= dir_left_n;
            ball_x    <= x_n;
            ball_y    <= y_n;
            vy        <= vy_n;
            phase     <= phase_n;
            speed     <= speed_n;
            period    <= period_n;
            cnt       <= cnt_n;
            rem       <= rem_n;
            dvd       <= dvd_n;
            dcnt      <= dcnt_n;
            score     <= score_n;
            game_over <= over_n;
            win       <= win_n;
        end
    end

endmodule

// File: doc/ball_motion_engine.md
BALL_MOTION_ENGINE -- requirements
Module: ball_motion_engine

Interface
REQ-001 The module SHALL expose the following parameters (name, default, meaning):
  H_RES, 640, full-mode field width in pixels
  V_RES, 480, full-mode field height in pixels
  STEP_X, 10, x pixels moved per motion step
  GRAV_PERIOD, 4, motion steps per +1 increment of vy
  BASE_TICKS, 270000, clock ticks per step at speed 1
  CW, 20, step-period counter and divider width
  MAX_SCORE, 15, returns needed to win
REQ-002 The module SHALL have one clock and a synchronous, active-high reset; ports (name, direction, width, meaning):
  clk_25MHZ  in  1  sole clock, all state on rising edge
  reset  in  1  synchronous active-high reset
  upscale  in  1  1 = full H_RES x V_RES field, 0 = half field
  restart  in  1  pulse that leaves OVER
  collision_detected  in  1  paddle hit
  estimated_speed  in  10  paddle speed
  rx_valid / rx_ready  in / out  1  incoming-ball handshake
  rx_y, rx_vy, rx_grav, rx_speed  in  10, 8 signed, 2, 8  incoming ball state
  tx_valid / tx_ready  out / in  1  outgoing-ball handshake
  tx_y, tx_vy, tx_grav, tx_speed  out  10, 8 signed, 2, 8  outgoing ball state
  ball_x, ball_y  out  10  ball position
  moving_left  out  1  ball travelling toward local paddle
  score  out  8  successful returns
  game_over, win  out  1  game finished; 1 = win, 0 = loss
  busy  out  1  state is not IDLE

Function
REQ-003 States SHALL be IDLE, DIV, RUN_LEFT, RUN_RIGHT, HANDOFF and OVER.
REQ-004 x_lim SHALL be H_RES-1 when upscale=1, else H_RES/2-1; y_max SHALL be V_RES-1 when upscale=1, else V_RES/2-1.
REQ-005 rx_ready SHALL be 1 only in IDLE; when rx_valid and rx_ready are both high, the module SHALL latch ball_y=rx_y, vy=rx_vy, grav phase=rx_grav, speed=max(rx_speed,1), set ball_x=x_lim and dir=left, then enter DIV.
REQ-006 DIV SHALL compute period=BASE_TICKS/speed with a serial restoring divider, one quotient bit per clock, taking exactly CW clocks; a quotient of 0 SHALL be clamped to 1; no motion SHALL occur in DIV.
REQ-007 On leaving DIV, the step counter SHALL be cleared and the state SHALL be RUN_LEFT or RUN_RIGHT per dir.
REQ-008 In RUN states, the counter SHALL increment each clock; when counter>=period, the module SHALL clear the counter and perform one step, so the first step falls on the (period+1)th RUN clock.
REQ-009 A step SHALL move x by STEP_X (minus if left, plus if right) and advance grav phase; if the phase was GRAV_PERIOD-1, vy_next=vy+1 and the phase wraps to 0.
REQ-010 A step SHALL compute y_new=y+vy (old vy) in 11-bit signed arithmetic; if y_new>=y_max: y=y_max, vy=-vy_next; else if y_new<=0: y=0, vy=-vy_next; otherwise y=y_new.
REQ-011 In RUN_LEFT, collision_detected SHALL take priority over a step in the same clock: set speed=max(estimated_speed,2) saturated to 255, dir=right, increment score, then enter DIV.
REQ-012 collision_detected SHALL be ignored in every state except RUN_LEFT.
REQ-013 In RUN_LEFT, a step that would take x below 0 (x<STEP_X) SHALL set x=0, game_over=1, win=0 and enter OVER.
REQ-014 In RUN_RIGHT, if score==MAX_SCORE the module SHALL set game_over=1, win=1 and enter OVER; otherwise, a step with x+STEP_X>x_lim SHALL set x=x_lim and enter HANDOFF.
REQ-015 In HANDOFF, tx_valid SHALL be 1 and tx_y, tx_vy, tx_grav, tx_speed SHALL hold ball state stable until the clock where tx_ready=1, after which the state SHALL be IDLE and tx_valid SHALL be 0.
REQ-016 In OVER, outputs SHALL hold; restart=1 SHALL clear score, game_over and win and enter IDLE.
REQ-017 moving_left SHALL be 1 only in RUN_LEFT, or in DIV when dir=left.
REQ-018 The score register SHALL saturate at 255.

Reset
REQ-019 When reset=1 at a clock edge, the module SHALL enter IDLE regardless of current state, including mid-DIV or mid-HANDOFF, and clear ball_x, ball_y, vy, grav phase, counter, score, game_over, win and tx_valid to 0 and speed to 1.
REQ-020 rx_ready SHALL be 0 while reset=1 and 1 in the first clock after reset deasserts.

Verification (bench parameters: H_RES=64, V_RES=48, STEP_X=4, GRAV_PERIOD=4, BASE_TICKS=100, CW=8, MAX_SCORE=2)
REQ-021 Reset during DIV -> next clock: IDLE, all outputs 0, busy=0, rx_ready=1.
REQ-022 upscale=1, rx handshake with y=10, vy=-2, grav=0, speed=4 -> 8 DIV clocks, period=25; first step on the 26th RUN_LEFT clock: x 63->59, y=8, phase=1.
REQ-023 y=1, vy=-3, phase=0 at a step -> y=0, vy=+3.
REQ-024 Collision in RUN_LEFT with estimated_speed=1 in the same clock as a due step -> no step, speed=2, period=50, score=1, moving_left=0 after DIV.
REQ-025 Right-edge step with tx_ready held low 5 clocks -> tx_valid=1 with stable fields for all 5 clocks; IDLE the clock after tx_ready=1.
REQ-026 Ball reaches x<4 in RUN_LEFT with no collision -> game_over=1, win=0; restart -> IDLE with score=0, game_over=0.
